sr_cntr_seq: RTL and testbench
==============================

Name: sr_cntr_seq

Overview:
Sequencer for the dual shift-register / up-down counter / adder datapath (SCHEME-style datapath). It accepts one operand byte and a direction flag over a start handshake. It serialises the operand MSB-first onto the shared shift-register input, pulses the counter enable once, captures the 8-bit adder sum and presents it on a valid/ready result port. It is the only agent that drives the datapath control inputs.

Parameters:
W, 8, operand/result width; equals shift-register depth.
CNT_W, 4, width of internal bit counter; must satisfy 2^CNT_W > W.

Ports:
clk  in  1  system clock; all state updates on rising edge.
res  in  1  reset; synchronous, active-low. Sampled on rising edge of clk; 0 resets all block state.
start  in  1  request to run one operation.
start_ready  out  1  high only in IDLE; start accepted on an edge where start && start_ready.
op_in  in  W  operand; sampled on the accepting edge.
op_inc  in  1  direction; 1 = increment, 0 = decrement; sampled on the accepting edge.
dp_clr  out  1  active-high clear to datapath res input.
sr_d  out  1  serial data to both shift registers.
cntr_en  out  1  counter EN.
cntr_inc  out  1  counter inc.
sum_in  in  W  datapath adder output (out).
result  out  W  captured sum.
result_valid  out  1  result available.
result_ready  in  1  consumer accepts result.
busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values (res=0):
  - state=IDLE, result=0, result_valid=0, busy=0, sr_d=0, cntr_en=0, cntr_inc=0.
  - dp_clr=1: the datapath is held cleared during reset and for exactly one cycle after res returns high.
- States: IDLE, CLEAR, SHIFT, COUNT, SETTLE, DONE.
- IDLE:
  - start_ready=1.
  - On the accepting edge: latch op_in and op_inc into op_reg/inc_reg, then go to CLEAR.
  - If start is low, stay in IDLE.
- CLEAR (1 cycle):
  - dp_clr=1; then go to SHIFT with bit_cnt=0.
- SHIFT (W cycles):
  - sr_d = op_reg[W-1-bit_cnt]; bit_cnt increments each edge.
  - On the edge where bit_cnt==W-1, go to COUNT.
  - After W edges, shift-register q == op_reg.
- COUNT (1 cycle):
  - cntr_en=1, cntr_inc=inc_reg. This is the only cycle in which cntr_en is high.
  - Then go to SETTLE.
- SETTLE (1 cycle):
  - Counter outputs are now op_reg±1 (mod 2^W).
  - On the exit edge: result<=sum_in, result_valid<=1, then go to DONE.
- DONE:
  - result_valid=1; result is held stable.
  - On an edge with result_ready=1: result_valid<=0, go to IDLE.
- Latency: counting the accepting edge as edge 0, result_valid rises at edge W+3 (edge 11 for W=8). The next start can be accepted one cycle after the result handshake.
- Arithmetic:
  - Both shift registers receive the same bits, so expected result = (2*((op±1) mod 2^W)) mod 2^W.
  - Wrap-around is silent; the carry bit is not exported.
- Boundary conditions:
  - start while busy: ignored; no queueing, no side effect.
  - start and result_ready both high in DONE: only the result handshake completes; start must be re-presented in IDLE.
  - result_ready high outside DONE: ignored.
  - op_in/op_inc changing after acceptance: no effect.
  - res=0 mid-operation: the next edge forces IDLE and the reset values above, discards any pending result, and clears the datapath via dp_clr.

Decomposition:
- Package sr_cntr_pkg:
  - state enum (IDLE=0, CLEAR, SHIFT, COUNT, SETTLE, DONE; 3-bit encoding);
  - W default and CNT_W constants.
- One sub-module, op_serializer:
  - function: W-bit parallel-load, MSB-first parallel-in/serial-out shift with bit counter;
  - ports: load, shift, last flag.
- The FSM and result register remain in sr_cntr_seq.

Test Plan:
- Reset, then op_in=0x05, op_inc=1, start pulse -> sr_d sequence 0,0,0,0,0,1,0,1; cntr_en high exactly 1 cycle; result=0x0C with result_valid at edge 11.
- op_in=0x00, op_inc=0 -> counters wrap to 0xFF, result=0xFE.
- op_in=0xFF, op_inc=1 -> result=0x00; op_in=0x80, op_inc=1 -> result=0x02 (carry discarded).
- result_ready held low for 20 cycles in DONE, with start pulsed repeatedly -> result stable, start_ready=0, no new operation; result_ready=1 -> IDLE next edge.
- res=0 asserted during SHIFT (bit 3) -> next edge IDLE, busy=0, dp_clr=1 until one cycle after release; a following op 0x05 inc again yields 0x0C.
- Back-to-back: handshake result, start asserted the following cycle -> accepted; second result correct and independent of the first.

Source files
------------

// File: rtl/sr_cntr_pkg.sv
// Shared constants and FSM state type for the shift-register / counter sequencer.
package sr_cntr_pkg;

    // Operand/result width; also the depth of the datapath shift registers.
    localparam int W_DEF     = 8;
    // Bit-counter width; 2**CNT_W_DEF must exceed W_DEF.
    localparam int CNT_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        COUNT  = 3'd3,
        SETTLE = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage : sr_cntr_pkg

// File: rtl/sr_cntr_seq_if.sv
// Host-side request/result bundle of the sequencer: start handshake with
// operand, and valid/ready result return.
interface sr_cntr_seq_if #(
    parameter int W = sr_cntr_pkg::W_DEF
);
    logic         start;
    logic         start_ready;
    logic [W-1:0] op_in;
    logic         op_inc;
    logic [W-1:0] result;
    logic         result_valid;
    logic         result_ready;

    // Requester side: issues operations and consumes results.
    modport master (
        output start, op_in, op_inc, result_ready,
        input  start_ready, result, result_valid
    );

    // Sequencer side.
    modport slave (
        input  start, op_in, op_inc, result_ready,
        output start_ready, result, result_valid
    );
endinterface : sr_cntr_seq_if

// File: rtl/op_serializer.sv
// Parallel-load, MSB-first parallel-in/serial-out shifter with a bit counter.
// ser_o is the register MSB, so it is a flop output and falls back to 0 once
// every loaded bit has been shifted out (zeros are shifted in from the LSB).
module op_serializer
    import sr_cntr_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         res,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] par_i,
    output logic         ser_o,
    output logic         last_o
);

    logic [W-1:0]     sreg_q;
    logic [CNT_W-1:0] cnt_q;

    // Load the operand, then move one bit towards the MSB per shift cycle.
    always_ff @(posedge clk) begin
        if (!res) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            sreg_q <= par_i;
            cnt_q  <= '0;
        end else if (shift_i) begin
            sreg_q <= {sreg_q[W-2:0], 1'b0};
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    assign ser_o  = sreg_q[W-1];
    // High while the final (LSB) bit of the operand is being presented.
    assign last_o = (cnt_q == CNT_W'(W - 1));

endmodule : op_serializer

// File: rtl/sr_cntr_seq.sv
// Sequencer for the dual shift-register / up-down counter / adder datapath.
// Accepts one operand, clears the datapath, shifts the operand in MSB-first,
// pulses the counter once, then captures and returns the adder sum.
module sr_cntr_seq
    import sr_cntr_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               res,
    sr_cntr_seq_if.slave       host,
    output logic               dp_clr,
    output logic               sr_d,
    output logic               cntr_en,
    output logic               cntr_inc,
    input  logic [W-1:0]       sum_in,
    output logic               busy
);

    state_t       state_q, state_d;
    logic [W-1:0] op_q;
    logic         inc_q;
    logic         dp_clr_q, dp_clr_d;
    logic         cntr_en_q, cntr_en_d;
    logic         cntr_inc_q, cntr_inc_d;
    logic         busy_q, busy_d;
    logic         start_ready_q, start_ready_d;
    logic         result_valid_q, result_valid_d;
    logic [W-1:0] result_q;

    logic         accept;
    logic         ser_load;
    logic         ser_shift;
    logic         ser_last;

    assign accept    = (state_q == IDLE) && host.start && start_ready_q;
    // The serializer is loaded during CLEAR so its MSB is already on sr_d in
    // the first SHIFT cycle.
    assign ser_load  = (state_q == CLEAR);
    assign ser_shift = (state_q == SHIFT);

    op_serializer #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_ser (
        .clk     (clk),
        .res     (res),
        .load_i  (ser_load),
        .shift_i (ser_shift),
        .par_i   (op_q),
        .ser_o   (sr_d),
        .last_o  (ser_last)
    );

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)            state_d = CLEAR;
            CLEAR:                          state_d = SHIFT;
            SHIFT:   if (ser_last)          state_d = COUNT;
            COUNT:                          state_d = SETTLE;
            SETTLE:                         state_d = DONE;
            DONE:    if (host.result_ready) state_d = IDLE;
            default:                        state_d = IDLE;
        endcase

        dp_clr_d       = (state_d == CLEAR);
        cntr_en_d      = (state_d == COUNT);
        cntr_inc_d     = (state_d == COUNT) && inc_q;
        busy_d         = (state_d != IDLE);
        start_ready_d  = (state_d == IDLE);
        result_valid_d = (state_d == DONE);
    end

    // State and registered outputs; reset holds the datapath cleared.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q        <= IDLE;
            dp_clr_q       <= 1'b1;
            cntr_en_q      <= 1'b0;
            cntr_inc_q     <= 1'b0;
            busy_q         <= 1'b0;
            start_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dp_clr_q       <= dp_clr_d;
            cntr_en_q      <= cntr_en_d;
            cntr_inc_q     <= cntr_inc_d;
            busy_q         <= busy_d;
            start_ready_q  <= start_ready_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Operand latch on acceptance and result capture on the SETTLE exit edge.
    always_ff @(posedge clk) begin
        if (!res) begin
            op_q     <= '0;
            inc_q    <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= host.op_in;
                inc_q <= host.op_inc;
            end
            if (state_q == SETTLE) begin
                result_q <= sum_in;
            end
        end
    end

    assign dp_clr            = dp_clr_q;
    assign cntr_en           = cntr_en_q;
    assign cntr_inc          = cntr_inc_q;
    assign busy              = busy_q;
    assign host.start_ready  = start_ready_q;
    assign host.result_valid = result_valid_q;
    assign host.result       = result_q;

endmodule : sr_cntr_seq

// File: tb/tb_sr_cntr_seq.sv
// Directed bench for sr_cntr_seq with a behavioural model of the datapath:
// two registers that shift sr_d in, count by one on cntr_en, and clear on
// dp_clr; sum_in is their 8-bit sum.
module tb_sr_cntr_seq;

    logic       clk = 1'b0;
    logic       res;
    logic       dp_clr;
    logic       sr_d;
    logic       cntr_en;
    logic       cntr_inc;
    logic [7:0] sum_in;
    logic       busy;

    logic [7:0] dp_a, dp_b;

    int n_chk  = 0;
    int n_pass = 0;

    sr_cntr_seq_if #(.W(8)) host_if ();

    sr_cntr_seq #(.W(8), .CNT_W(4)) dut (
        .clk      (clk),
        .res      (res),
        .host     (host_if),
        .dp_clr   (dp_clr),
        .sr_d     (sr_d),
        .cntr_en  (cntr_en),
        .cntr_inc (cntr_inc),
        .sum_in   (sum_in),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Datapath model: clear, count, or shift in the serial bit.
    always @(posedge clk) begin
        if (dp_clr) begin
            dp_a <= 8'h00;
            dp_b <= 8'h00;
        end else if (cntr_en) begin
            dp_a <= cntr_inc ? dp_a + 8'd1 : dp_a - 8'd1;
            dp_b <= cntr_inc ? dp_b + 8'd1 : dp_b - 8'd1;
        end else begin
            dp_a <= {dp_a[6:0], sr_d};
            dp_b <= {dp_b[6:0], sr_d};
        end
    end
    assign sum_in = dp_a + dp_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation; edge 0 is the accepting edge.
    task automatic run_op(input logic [7:0] op, input logic inc, input logic [7:0] exp,
                          input bit noise, input bit handshake);
        int         waitc;
        logic [7:0] seq;
        int         en_cnt;
        logic       inc_seen;
        int         early;
        waitc = 0;
        while (!host_if.start_ready && waitc < 50) begin
            tick();
            waitc++;
        end
        chk("start_ready_wait", host_if.start_ready, 1);
        host_if.start  = 1'b1;
        host_if.op_in  = op;
        host_if.op_inc = inc;
        tick();
        host_if.start  = 1'b0;
        host_if.op_in  = ~op;
        host_if.op_inc = ~inc;
        chk("busy_after_accept", busy, 1);
        chk("start_ready_busy", host_if.start_ready, 0);
        chk("dp_clr_in_clear", dp_clr, 1);
        seq = 8'h00; en_cnt = 0; inc_seen = 1'b0; early = 0;
        for (int k = 1; k <= 11; k++) begin
            if (noise) begin
                host_if.start        = k[0];
                host_if.result_ready = 1'b1;
                host_if.op_in        = 8'($urandom);
            end
            tick();
            if (k == 1) chk("dp_clr_after_clear", dp_clr, 0);
            if (k <= 8) seq = {seq[6:0], sr_d};
            if (cntr_en) begin
                en_cnt++;
                inc_seen = cntr_inc;
            end
            if (k < 11 && host_if.result_valid) early++;
        end
        chk("sr_d_sequence", seq, op);
        chk("cntr_en_cycles", en_cnt, 1);
        chk("cntr_inc_value", inc_seen, inc);
        chk("valid_early", early, 0);
        chk("valid_edge11", host_if.result_valid, 1);
        chk("result_value", host_if.result, exp);
        $display("op 0x%02h inc=%0d result 0x%02h", op, inc, host_if.result);
        host_if.start = 1'b0;
        if (handshake) begin
            host_if.result_ready = 1'b1;
            host_if.start        = noise;
            tick();
            host_if.start        = 1'b0;
            host_if.result_ready = 1'b0;
            chk("valid_after_hs", host_if.result_valid, 0);
            chk("busy_after_hs", busy, 0);
            chk("start_ready_after_hs", host_if.start_ready, 1);
            if (noise) begin
                tick();
                chk("start_not_queued", busy, 0);
            end
        end else begin
            host_if.result_ready = 1'b0;
        end
    endtask

    initial begin
        res                  = 1'b0;
        host_if.start        = 1'b0;
        host_if.op_in        = 8'h00;
        host_if.op_inc       = 1'b0;
        host_if.result_ready = 1'b0;
        repeat (3) tick();
        chk("rst_dp_clr", dp_clr, 1);
        chk("rst_busy", busy, 0);
        chk("rst_result", host_if.result, 0);
        chk("rst_valid", host_if.result_valid, 0);
        chk("rst_sr_d", sr_d, 0);
        chk("rst_cntr_en", cntr_en, 0);
        chk("rst_cntr_inc", cntr_inc, 0);
        chk("rst_start_ready", host_if.start_ready, 1);
        res = 1'b1;
        #1;
        chk("rel_dp_clr_hold", dp_clr, 1);
        tick();
        chk("rel_dp_clr_drop", dp_clr, 0);

        run_op(8'h05, 1'b1, 8'h0C, 1'b0, 1'b1);
        run_op(8'h00, 1'b0, 8'hFE, 1'b0, 1'b1);
        run_op(8'hFF, 1'b1, 8'h00, 1'b1, 1'b1);
        run_op(8'h80, 1'b1, 8'h02, 1'b0, 1'b1);
        run_op(8'h3C, 1'b0, 8'h76, 1'b0, 1'b1);

        // Result held in DONE while start is pulsed.
        run_op(8'hA1, 1'b1, 8'h44, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            host_if.start = i[0];
            host_if.op_in = 8'($urandom);
            tick();
            chk("hold_result", host_if.result, 8'h44);
            chk("hold_valid", host_if.result_valid, 1);
            chk("hold_start_ready", host_if.start_ready, 0);
        end
        host_if.start        = 1'b0;
        host_if.result_ready = 1'b1;
        tick();
        host_if.result_ready = 1'b0;
        chk("hold_release_valid", host_if.result_valid, 0);
        chk("hold_release_busy", busy, 0);
        tick();
        chk("hold_no_new_op", busy, 0);

        // Reset in the middle of SHIFT (bit 3 on sr_d).
        host_if.start  = 1'b1;
        host_if.op_in  = 8'h05;
        host_if.op_inc = 1'b1;
        tick();
        host_if.start = 1'b0;
        repeat (4) tick();
        chk("mid_busy", busy, 1);
        res = 1'b0;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start_ready", host_if.start_ready, 1);
        chk("mid_rst_valid", host_if.result_valid, 0);
        chk("mid_rst_dp_clr", dp_clr, 1);
        chk("mid_rst_sr_d", sr_d, 0);
        chk("mid_rst_cntr_en", cntr_en, 0);
        tick();
        res = 1'b1;
        #1;
        chk("mid_rel_dp_clr_hold", dp_clr, 1);
        tick();
        chk("mid_rel_dp_clr_drop", dp_clr, 0);
        run_op(8'h05, 1'b1, 8'h0C, 1'b0, 1'b1);
        run_op(8'h05, 1'b0, 8'h08, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_sr_cntr_seq
